pwm_breathe_multi: RTL

//  Multi-channel breathing-LED PWM generator; successor to the single-channel 128-level breather.
//  One shared prescaler and PWM index counter drive CHANNELS outputs, each with its own mode.

---
 rtl/pwm_breathe_pkg.sv | 17 +
 rtl/pwm_chan.sv | 61 ++++++
 rtl/pwm_breathe_multi.sv | 80 ++++++++
 3 files changed

// File: rtl/pwm_breathe_pkg.sv
// Shared mode encoding and phase helper for the multi-channel breathing PWM.
package pwm_breathe_pkg;

  typedef enum logic [1:0] {
    PWM_MODE_OFF     = 2'd0,
    PWM_MODE_ON      = 2'd1,
    PWM_MODE_BREATHE = 2'd2,
    PWM_MODE_FIXED   = 2'd3
  } pwm_mode_e;

  // Evenly spaced starting point of channel ch on the 2^(pwm_bits+1)-step breathing ramp.
  function automatic int unsigned phase_offset(int unsigned ch, int unsigned channels,
                                               int unsigned pwm_bits);
    return ch * ((32'd1 << (pwm_bits + 1)) / channels);
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM output: shadowed mode/duty, staggered breathing phase and registered output.
module pwm_chan
  import pwm_breathe_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PWM_BITS = 7,
  parameter int unsigned CH_IDX   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] idx,
  input  logic [PWM_BITS:0]   ramp,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  localparam int unsigned       PhOffInt = phase_offset(CH_IDX, CHANNELS, PWM_BITS);
  localparam logic [PWM_BITS:0] PhOff    = PhOffInt[PWM_BITS:0];

  pwm_mode_e           mode_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS:0]   ph;
  logic                pol;
  logic [PWM_BITS-1:0] lvl;
  logic                pwm_d;

  // Settings only take effect at a period boundary so a mid-period write never makes a runt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= PWM_MODE_OFF;
      duty_q  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wrap || !en) begin
        mode_q <= pwm_mode_e'(mode);
        duty_q <= duty;
      end
      pwm_out <= pwm_d;
    end
  end

  always_comb begin
    ph    = ramp + PhOff;
    pol   = ph[PWM_BITS];
    lvl   = ph[PWM_BITS-1:0];
    pwm_d = 1'b0;
    if (en) begin
      unique case (mode_q)
        PWM_MODE_OFF:     pwm_d = 1'b0;
        PWM_MODE_ON:      pwm_d = 1'b1;
        PWM_MODE_BREATHE: pwm_d = pol ^ (idx > lvl);
        PWM_MODE_FIXED:   pwm_d = (idx < duty_q);
        default:          pwm_d = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pwm_breathe_multi.sv
// Multi-channel breathing-LED PWM: shared prescaler, PWM index and breathing ramp
// feeding one pwm_chan per output.
module pwm_breathe_multi
  import pwm_breathe_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned PWM_BITS      = 7,
  parameter int unsigned PRESCALE_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [PRESCALE_BITS-1:0]     prescale,
  input  logic [2*CHANNELS-1:0]        mode,
  input  logic [PWM_BITS*CHANNELS-1:0] duty,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic                         period_tick
);

  if (CHANNELS < 1 || (CHANNELS & (CHANNELS - 1)) != 0) begin : g_bad_channels
    $error("pwm_breathe_multi: CHANNELS must be a power of two");
  end

  logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]      idx_q, idx_d;
  logic [PWM_BITS:0]        ramp_q, ramp_d;
  logic                     tick;
  logic                     wrap;

  // >= rather than == so lowering prescale below the running count still ticks promptly.
  always_comb begin
    tick      = en && (pre_cnt_q >= prescale);
    wrap      = tick && (idx_q == {PWM_BITS{1'b1}});
    pre_cnt_d = pre_cnt_q;
    idx_d     = idx_q;
    ramp_d    = ramp_q;
    if (tick) begin
      pre_cnt_d = '0;
      idx_d     = idx_q + PWM_BITS'(1);
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + PRESCALE_BITS'(1);
    end
    if (wrap) begin
      ramp_d = ramp_q + (PWM_BITS + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q   <= '0;
      idx_q       <= '0;
      ramp_q      <= '0;
      period_tick <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      idx_q       <= idx_d;
      ramp_q      <= ramp_d;
      period_tick <= wrap;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_chan #(
      .CHANNELS(CHANNELS),
      .PWM_BITS(PWM_BITS),
      .CH_IDX  (i)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .wrap   (wrap),
      .idx    (idx_q),
      .ramp   (ramp_q),
      .mode   (mode[2*i +: 2]),
      .duty   (duty[PWM_BITS*i +: PWM_BITS]),
      .pwm_out(pwm_out[i])
    );
  end

endmodule
